// File: rtl/serial_arb_pkg.sv
// Shared types and constants for serial_rx_arbiter.
package serial_arb_pkg;
  localparam int BYTE_W     = 8;
  localparam int DROP_CNT_W = 8;

  typedef enum logic {
    ARB_EMPTY,
    ARB_VALID
  } arb_state_t;
endpackage

// File: rtl/serial_rx_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first requester after last_grant, wrapping at NUM_CH-1.
module rr_arbiter #(
  parameter int NUM_CH = 4
) (
  input  logic [NUM_CH-1:0]         req,
  input  logic [$clog2(NUM_CH)-1:0] last_grant,
  output logic                      gnt_vld,
  output logic [$clog2(NUM_CH)-1:0] gnt_idx
);
  localparam int CH_W = $clog2(NUM_CH);

  always_comb begin
    int             pos;
    logic [CH_W-1:0] idx;
    gnt_vld = 1'b0;
    gnt_idx = '0;
    pos     = 0;
    idx     = '0;
    for (int k = 1; k <= NUM_CH; k++) begin
      pos = int'(last_grant) + k;
      if (pos >= NUM_CH) pos = pos - NUM_CH;
      idx = CH_W'(pos);
      if (!gnt_vld && req[idx]) begin
        gnt_vld = 1'b1;
        gnt_idx = idx;
      end
    end
  end
endmodule

// File: rtl/serial_rx_arbiter.sv
// Merges NUM_CH serial byte receivers onto one valid/ready byte stream.
// Optional per-channel drop counters: define SERIAL_ARB_DROP_CNT_EN.
//
// state     | meaning
// ARB_EMPTY | output register free, out_valid = 0
// ARB_VALID | output register holds a byte awaiting out_ready
module serial_rx_arbiter
  import serial_arb_pkg::*;
#(
  parameter int NUM_CH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_CH-1:0]          rx_done,
  input  logic [NUM_CH*BYTE_W-1:0]   rx_byte,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [BYTE_W-1:0]          out_byte,
  output logic [$clog2(NUM_CH)-1:0]  out_ch,
  output logic [NUM_CH-1:0]          overrun,
  input  logic [NUM_CH-1:0]          ovr_clr
`ifdef SERIAL_ARB_DROP_CNT_EN
  ,
  output logic [NUM_CH*DROP_CNT_W-1:0] drop_cnt
`endif
);
  localparam int CH_W = $clog2(NUM_CH);

  logic [NUM_CH-1:0]        done_q;
  logic [NUM_CH*BYTE_W-1:0] byte_q;
  logic [BYTE_W-1:0]        hold [NUM_CH];
  logic [NUM_CH-1:0]        full;
  logic [NUM_CH-1:0]        drain;
  logic [NUM_CH-1:0]        drop;
  logic [CH_W-1:0]          last_grant;
  logic [CH_W-1:0]          gnt_idx;
  logic                     gnt_vld;
  logic                     load;
  arb_state_t               state;

  rr_arbiter #(.NUM_CH(NUM_CH)) u_rr (
    .req        (full),
    .last_grant (last_grant),
    .gnt_vld    (gnt_vld),
    .gnt_idx    (gnt_idx)
  );

  assign load = (state == ARB_EMPTY) || (out_valid && out_ready);

  // A slot being granted this cycle is free for a byte arriving in the same cycle.
  always_comb begin
    drain = '0;
    if (load && gnt_vld) drain[gnt_idx] = 1'b1;
    drop = done_q & full & ~drain;
  end

  // Receiver pulses pass through one input flop before reaching the holding registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      done_q  <= '0;
      byte_q  <= '0;
      full    <= '0;
      overrun <= '0;
      for (int i = 0; i < NUM_CH; i++) hold[i] <= '0;
    end else begin
      done_q <= rx_done;
      byte_q <= rx_byte;
      for (int i = 0; i < NUM_CH; i++) begin
        if (done_q[i] && !drop[i]) begin
          hold[i] <= byte_q[i*BYTE_W +: BYTE_W];
          full[i] <= 1'b1;
        end else if (drain[i]) begin
          full[i] <= 1'b0;
        end
        if (drop[i])          overrun[i] <= 1'b1;
        else if (ovr_clr[i])  overrun[i] <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ARB_EMPTY;
      out_valid  <= 1'b0;
      out_byte   <= '0;
      out_ch     <= '0;
      last_grant <= CH_W'(NUM_CH - 1);
    end else if (load) begin
      if (gnt_vld) begin
        out_byte   <= hold[gnt_idx];
        out_ch     <= gnt_idx;
        last_grant <= gnt_idx;
        state      <= ARB_VALID;
        out_valid  <= 1'b1;
      end else begin
        state     <= ARB_EMPTY;
        out_valid <= 1'b0;
      end
    end
  end

`ifdef SERIAL_ARB_DROP_CNT_EN
  logic [DROP_CNT_W-1:0] cnt [NUM_CH];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_CH; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (drop[i]) begin
          if (ovr_clr[i])        cnt[i] <= DROP_CNT_W'(1);
          else if (cnt[i] != '1) cnt[i] <= cnt[i] + 1'b1;
        end else if (ovr_clr[i]) begin
          cnt[i] <= '0;
        end
      end
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_cnt
    assign drop_cnt[g*DROP_CNT_W +: DROP_CNT_W] = cnt[g];
  end
`endif
endmodule

// File: tb/tb_serial_rx_arbiter.sv
// Self-checking bench for serial_rx_arbiter (NUM_CH = 4): timing vectors plus scoreboard.
module tb_serial_rx_arbiter;
  localparam int NUM_CH = 4;

  logic                  clk = 1'b0;
  logic                  reset;
  logic [NUM_CH-1:0]     rx_done;
  logic [NUM_CH*8-1:0]   rx_byte;
  logic                  out_valid;
  logic                  out_ready;
  logic [7:0]            out_byte;
  logic [1:0]            out_ch;
  logic [NUM_CH-1:0]     overrun;
  logic [NUM_CH-1:0]     ovr_clr;
`ifdef SERIAL_ARB_DROP_CNT_EN
  logic [NUM_CH*8-1:0]   drop_cnt;
`endif

  serial_rx_arbiter #(.NUM_CH(NUM_CH)) dut (
    .clk       (clk),
    .reset     (reset),
    .rx_done   (rx_done),
    .rx_byte   (rx_byte),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_byte  (out_byte),
    .out_ch    (out_ch),
    .overrun   (overrun),
    .ovr_clr   (ovr_clr)
`ifdef SERIAL_ARB_DROP_CNT_EN
    ,
    .drop_cnt  (drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [1:0] ch;
    logic [7:0] b;
  } exp_t;
  exp_t sb_q[$];

  typedef struct {
    int         ch;
    logic [7:0] b;
    logic [1:0] exp_ch;
    logic [7:0] exp_byte;
  } vec_t;
  vec_t vecs[4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input logic [1:0] ch, input logic [7:0] b);
    exp_t e;
    e.ch = ch;
    e.b  = b;
    sb_q.push_back(e);
  endtask

  // Called just after a rising edge; the pulse is sampled at the next edge.
  task automatic pulse(input logic [NUM_CH-1:0] d, input logic [NUM_CH*8-1:0] b);
    rx_done = d;
    rx_byte = b;
    @(posedge clk); #1;
    rx_done = '0;
  endtask

  task automatic pulse1(input int ch, input logic [7:0] b);
    logic [NUM_CH*8-1:0] v;
    logic [NUM_CH-1:0]   d;
    v = '0;
    d = '0;
    v[ch*8 +: 8] = b;
    d[ch] = 1'b1;
    pulse(d, v);
  endtask

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Scoreboard: a transfer is committed whenever valid and ready are both high.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset && out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          chk("sb_unexpected_valid", 32'(out_valid), 32'd0);
        end else begin
          e = sb_q.pop_front();
          chk("sb_ch", 32'(out_ch), 32'(e.ch));
          chk("sb_byte", 32'(out_byte), 32'(e.b));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0] = '{ch: 2, b: 8'hA5, exp_ch: 2'd2, exp_byte: 8'hA5};
    vecs[1] = '{ch: 0, b: 8'h3C, exp_ch: 2'd0, exp_byte: 8'h3C};
    vecs[2] = '{ch: 3, b: 8'hFF, exp_ch: 2'd3, exp_byte: 8'hFF};
    vecs[3] = '{ch: 1, b: 8'h00, exp_ch: 2'd1, exp_byte: 8'h00};

    reset     = 1'b1;
    rx_done   = '0;
    rx_byte   = '0;
    out_ready = 1'b1;
    ovr_clr   = '0;
    step(2);
    reset = 1'b0;
    step(1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_byte", 32'(out_byte), 32'd0);
    chk("rst_out_ch", 32'(out_ch), 32'd0);
    chk("rst_overrun", 32'(overrun), 32'd0);

    // Single-byte latency: sampled at edge N, valid after N+2 for one cycle.
    for (int v = 0; v < 4; v++) begin
      push(vecs[v].exp_ch, vecs[v].exp_byte);
      pulse1(vecs[v].ch, vecs[v].b);
      step(1);
      chk("lat_not_early", 32'(out_valid), 32'd0);
      step(1);
      chk("lat_valid", 32'(out_valid), 32'd1);
      chk("lat_byte", 32'(out_byte), 32'(vecs[v].exp_byte));
      chk("lat_ch", 32'(out_ch), 32'(vecs[v].exp_ch));
      step(1);
      chk("lat_one_cycle", 32'(out_valid), 32'd0);
      chk("lat_overrun", 32'(overrun), 32'd0);
      step(1);
    end

    // All four channels at once just after reset: ch0..ch3 back to back.
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    for (int k = 0; k < 4; k++) push(2'(k), 8'h10 + 8'(k * 8'h11));
    pulse(4'b1111, {8'h43, 8'h32, 8'h21, 8'h10});
    step(1);
    chk("burst_not_early", 32'(out_valid), 32'd0);
    for (int k = 0; k < 4; k++) begin
      step(1);
      chk("burst_valid", 32'(out_valid), 32'd1);
      chk("burst_ch", 32'(out_ch), 32'(k));
    end
    step(1);
    chk("burst_then_empty", 32'(out_valid), 32'd0);

    // After ch1 wins, ch1 and ch3 together: ch3 goes first.
    push(2'd1, 8'h77);
    pulse1(1, 8'h77);
    step(4);
    push(2'd3, 8'h63);
    push(2'd1, 8'h61);
    pulse(4'b1010, {8'h63, 8'h00, 8'h61, 8'h00});
    step(2);
    chk("rr_first_ch3", 32'(out_ch), 32'd3);
    step(1);
    chk("rr_then_ch1", 32'(out_ch), 32'd1);
    step(2);

    // Stall with ch0 in the output register, then a held byte and a dropped byte.
    out_ready = 1'b0;
    pulse1(0, 8'h5A);
    step(2);
    pulse1(0, 8'h11);
    pulse1(0, 8'h22);
    step(1);
    chk("stall_valid", 32'(out_valid), 32'd1);
    chk("stall_byte", 32'(out_byte), 32'h5A);
    chk("stall_overrun", 32'(overrun), 32'b0001);
`ifdef SERIAL_ARB_DROP_CNT_EN
    chk("drop_cnt_one", 32'(drop_cnt[7:0]), 32'd1);
`endif
    ovr_clr = 4'b0001;
    step(1);
    ovr_clr = '0;
    chk("ovr_clr", 32'(overrun), 32'd0);
    chk("stall_byte_held", 32'(out_byte), 32'h5A);
`ifdef SERIAL_ARB_DROP_CNT_EN
    chk("drop_cnt_clr", 32'(drop_cnt[7:0]), 32'd0);
`endif
    push(2'd0, 8'h5A);
    push(2'd0, 8'h11);
    out_ready = 1'b1;
    step(4);

    // New byte lands in the same cycle its channel is granted: accepted, no overrun.
    push(2'd0, 8'hB1);
    push(2'd0, 8'hB2);
    pulse1(0, 8'hB1);
    pulse1(0, 8'hB2);
    step(4);
    chk("grant_same_cycle_no_ovr", 32'(overrun), 32'd0);

    // Clear coinciding with a drop: the set wins.
    out_ready = 1'b0;
    pulse1(2, 8'hC0);
    step(2);
    pulse1(2, 8'hC1);
    pulse1(2, 8'hC2);
    ovr_clr = 4'b0100;
    step(1);
    ovr_clr = '0;
    chk("set_wins_overrun", 32'(overrun), 32'b0100);
`ifdef SERIAL_ARB_DROP_CNT_EN
    chk("set_wins_drop_cnt", 32'(drop_cnt[23:16]), 32'd1);
`endif
    push(2'd2, 8'hC0);
    push(2'd2, 8'hC1);
    out_ready = 1'b1;
    ovr_clr = 4'b0100;
    step(1);
    ovr_clr = '0;
    step(3);
    chk("set_wins_cleared", 32'(overrun), 32'd0);

    // Async reset while busy with two channels pending.
    out_ready = 1'b0;
    pulse(4'b0111, {8'h00, 8'hE2, 8'hE1, 8'hE0});
    step(3);
    chk("pre_rst_valid", 32'(out_valid), 32'd1);
    @(negedge clk); #2;
    reset = 1'b1;
    #1;
    chk("async_rst_valid", 32'(out_valid), 32'd0);
    chk("async_rst_byte", 32'(out_byte), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      step(1);
      chk("no_stale_after_rst", 32'(out_valid), 32'd0);
    end

    for (int k = 0; k < 20 && sb_q.size() != 0; k++) step(1);
    chk("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
